// File: rtl/p2s_rr_scheduler.sv
// Round-robin arbiter feeding one shared MSB-first parallel-to-serial shifter.
// A new word is granted in IDLE or on the LSB cycle of the current word, so words stream with no gap.
module p2s_rr_scheduler #(
  parameter int N   = 4,
  parameter int DW  = 4,
  parameter int IDW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      en_mask,
  input  logic [N-1:0]      req_valid,
  input  logic [N*DW-1:0]   req_data,
  output logic [N-1:0]      req_ready,
  output logic              ser_valid,
  output logic              ser_dout,
  output logic              ser_first,
  output logic              ser_last,
  output logic [IDW-1:0]    ser_id,
  output logic              busy
);

  localparam int BW = $clog2(DW);
  localparam logic [BW-1:0] BMAX = BW'(DW - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [BW-1:0]    r_bcnt;
  logic [BW-1:0]    w_bcnt_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   w_ptr_nxt;
  logic [IDW-1:0]   r_id;
  logic [IDW-1:0]   w_id_nxt;
  logic [DW-1:0]    r_shreg;
  logic [DW-1:0]    w_shreg_nxt;
  logic [N-1:0]     w_elig;
  logic             w_load_slot;
  logic             w_grant;
  logic [IDW-1:0]   w_gidx;
  logic [N-1:0]     w_ready;

  assign w_elig      = req_valid & en_mask;
  assign w_load_slot = (r_state == IDLE) || (r_bcnt == '0);

  // Circular search from ptr; walking k downward lets the nearest eligible index win.
  always_comb begin : rr_search
    logic [IDW:0]   v_sum;
    logic [IDW:0]   v_idx;
    logic [IDW-1:0] v_sel;
    logic           v_hit;
    w_grant = 1'b0;
    w_gidx  = '0;
    v_sum   = '0;
    v_idx   = '0;
    v_sel   = '0;
    v_hit   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      v_sum   = {1'b0, r_ptr} + (IDW+1)'(k);
      v_idx   = (v_sum >= (IDW+1)'(N)) ? (v_sum - (IDW+1)'(N)) : v_sum;
      v_sel   = v_idx[IDW-1:0];
      v_hit   = w_elig[v_sel];
      w_grant = w_grant | v_hit;
      w_gidx  = v_hit ? v_sel : w_gidx;
    end
  end

  // Next-state logic: load on a grant, drop to IDLE when nothing is eligible, otherwise shift.
  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    w_ptr_nxt   = r_ptr;
    w_id_nxt    = r_id;
    w_shreg_nxt = r_shreg;
    w_ready     = '0;
    if (w_load_slot) begin
      if (w_grant) begin
        w_ready[w_gidx] = 1'b1;
        w_shreg_nxt     = req_data[DW*int'(w_gidx) +: DW];
        w_bcnt_nxt      = BMAX;
        w_ptr_nxt       = (w_gidx == IDW'(N - 1)) ? '0 : (w_gidx + IDW'(1));
        w_id_nxt        = w_gidx;
        w_state_nxt     = SHIFT;
      end else begin
        // Clearing the shifter keeps ser_dout low while the lane is idle.
        w_shreg_nxt = '0;
        w_bcnt_nxt  = '0;
        w_state_nxt = IDLE;
      end
    end else begin
      w_shreg_nxt = {r_shreg[DW-2:0], 1'b0};
      w_bcnt_nxt  = r_bcnt - BW'(1);
      w_state_nxt = SHIFT;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_bcnt  <= '0;
      r_ptr   <= '0;
      r_id    <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_id    <= w_id_nxt;
      r_shreg <= w_shreg_nxt;
    end
  end

  // Handshake outputs are masked by reset so nothing is accepted while it is held.
  assign req_ready = w_ready & {N{rst}};
  assign busy      = rst & ((r_state == SHIFT) | (|w_ready));

  assign ser_valid = (r_state == SHIFT);
  assign ser_dout  = r_shreg[DW-1];
  assign ser_first = (r_state == SHIFT) & (r_bcnt == BMAX);
  assign ser_last  = (r_state == SHIFT) & (r_bcnt == '0);
  assign ser_id    = r_id;

endmodule

// File: tb/tb_p2s_rr_scheduler.sv
// Directed table-driven bench for p2s_rr_scheduler (N=4, DW=4), plus a hand-written reset-mid-word sequence.
module tb_p2s_rr_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  en_mask;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        ser_valid;
  logic        ser_dout;
  logic        ser_first;
  logic        ser_last;
  logic [1:0]  ser_id;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0]  en;
    logic [3:0]  vld;
    logic [15:0] dat;
    logic [3:0]  rdy;
    logic        sv;
    logic        sd;
    logic        sf;
    logic        sl;
    logic [1:0]  sid;
    logic        bsy;
  } vec_t;

  vec_t tbl[$];

  p2s_rr_scheduler #(.N(4), .DW(4), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_mask   (en_mask),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .ser_valid (ser_valid),
    .ser_dout  (ser_dout),
    .ser_first (ser_first),
    .ser_last  (ser_last),
    .ser_id    (ser_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] en, input logic [3:0] vld, input logic [15:0] dat,
                              input logic [3:0] rdy, input logic sv, input logic sd, input logic sf,
                              input logic sl, input logic [1:0] sid, input logic bsy);
    vec_t v;
    v.en = en; v.vld = vld; v.dat = dat; v.rdy = rdy; v.sv = sv;
    v.sd = sd; v.sf = sf; v.sl = sl; v.sid = sid; v.bsy = bsy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    chk({tag, ".req_ready"}, req_ready, v.rdy);
    chk({tag, ".ser_valid"}, {3'b000, ser_valid}, {3'b000, v.sv});
    chk({tag, ".ser_dout"},  {3'b000, ser_dout},  {3'b000, v.sd});
    chk({tag, ".ser_first"}, {3'b000, ser_first}, {3'b000, v.sf});
    chk({tag, ".ser_last"},  {3'b000, ser_last},  {3'b000, v.sl});
    chk({tag, ".ser_id"},    {2'b00, ser_id},     {2'b00, v.sid});
    chk({tag, ".busy"},      {3'b000, busy},      {3'b000, v.bsy});
  endtask

  // Entered just after a rising edge: drive, check mid-cycle, advance to next edge.
  task automatic run_vec(input string tag, input vec_t v);
    en_mask   = v.en;
    req_valid = v.vld;
    req_data  = v.dat;
    @(negedge clk);
    check_outs(tag, v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int gid [9];
    logic [3:0] gdat [8];
    logic [3:0] one;
    logic [3:0] rdy;
    vec_t zero;
    vec_t v;
    int w;
    int b;

    gid  = '{0, 1, 2, 3, 0, 1, 3, 0, 1};
    gdat = '{4'hA, 4'h5, 4'hF, 4'h0, 4'hA, 4'h5, 4'h0, 4'hA};
    one  = 4'b0001;
    zero = mk(4'hF, 4'hF, 16'h0F5A, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

    // Single word 1011 from requester 0
    tbl.push_back(mk(4'hF, 4'h1, 16'h000B, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1));
    tbl.push_back(mk(4'hF, 4'h0, 16'h0000, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1));
    tbl.push_back(mk(4'hF, 4'h0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1));
    tbl.push_back(mk(4'hF, 4'h0, 16'h0000, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1));
    tbl.push_back(mk(4'hF, 4'h0, 16'h0000, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1));
    tbl.push_back(mk(4'hF, 4'h0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    // Pointer wrap: grant 3 (data 6), then only 1 (data 9) and 2 (data 3)
    tbl.push_back(mk(4'hF, 4'h8, 16'h6000, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1));
    tbl.push_back(mk(4'hF, 4'h6, 16'h0390, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1));
    tbl.push_back(mk(4'hF, 4'h6, 16'h0390, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1));
    tbl.push_back(mk(4'hF, 4'h6, 16'h0390, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1));
    tbl.push_back(mk(4'hF, 4'h6, 16'h0390, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1));
    tbl.push_back(mk(4'hF, 4'h4, 16'h0390, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1));
    tbl.push_back(mk(4'hF, 4'h4, 16'h0390, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1));
    tbl.push_back(mk(4'hF, 4'h4, 16'h0390, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1));
    tbl.push_back(mk(4'hF, 4'h4, 16'h0390, 4'h4, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1));
    tbl.push_back(mk(4'hF, 4'h0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1));
    tbl.push_back(mk(4'hF, 4'h0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1));
    tbl.push_back(mk(4'hF, 4'h0, 16'h0000, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1));
    tbl.push_back(mk(4'hF, 4'h0, 16'h0000, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1));
    tbl.push_back(mk(4'hF, 4'h0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0));

    // Round-robin back-to-back (A,5,F,0), mask 1011 from cycle 14: grant ids from gid[]
    for (int c = 0; c <= 32; c++) begin
      rdy = ((c % 4) == 0) ? (one << gid[c / 4]) : 4'h0;
      if (c == 0) begin
        v = mk(4'hF, 4'hF, 16'h0F5A, rdy, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
      end else begin
        w = (c - 1) / 4;
        b = (c - 1) % 4;
        v = mk((c < 14) ? 4'hF : 4'hB, 4'hF, 16'h0F5A, rdy, 1'b1, gdat[w][3 - b],
               (b == 0), (b == 3), 2'(gid[w]), 1'b1);
      end
      tbl.push_back(v);
    end
    // Drain word from requester 1 (data 5)
    tbl.push_back(mk(4'hF, 4'h0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1));
    tbl.push_back(mk(4'hF, 4'h0, 16'h0000, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1));
    tbl.push_back(mk(4'hF, 4'h0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1));
    tbl.push_back(mk(4'hF, 4'h0, 16'h0000, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1));
    tbl.push_back(mk(4'hF, 4'h0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0));
    // Late/dropped valid on requester 1 during word 0
    tbl.push_back(mk(4'hF, 4'h1, 16'h000B, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1));
    tbl.push_back(mk(4'hF, 4'h0, 16'h0000, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1));
    tbl.push_back(mk(4'hF, 4'h2, 16'h00C0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1));
    tbl.push_back(mk(4'hF, 4'h0, 16'h0000, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1));
    tbl.push_back(mk(4'hF, 4'h0, 16'h0000, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1));
    tbl.push_back(mk(4'hF, 4'h0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));

    clk       = 1'b0;
    rst       = 1'b0;
    en_mask   = 4'hF;
    req_valid = 4'hF;
    req_data  = 16'h0F5A;
    #2;
    check_outs("por", zero);
    repeat (2) @(posedge clk);
    #1;
    check_outs("por_hold", zero);
    rst = 1'b1;

    for (int i = 0; i < 20; i++) run_vec($sformatf("row%0d", i), tbl[i]);

    // Reset in the second bit cycle of a word; outputs must clear at once
    run_vec("rmw0", mk(4'hF, 4'h1, 16'h000B, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1));
    run_vec("rmw1", mk(4'hF, 4'h0, 16'h0000, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1));
    rst       = 1'b0;
    req_valid = 4'hF;
    req_data  = 16'h0F5A;
    #1;
    check_outs("rmw_assert", zero);
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      check_outs($sformatf("rmw_hold%0d", r), zero);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;

    for (int i = 20; i < tbl.size(); i++) run_vec($sformatf("row%0d", i), tbl[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
